// File: rtl/mips32r1_wb_pkg.sv
// Shared types and constants for the mips32r1 Wishbone arbiter.
// Holds the arbiter state encoding, bus widths and grant helper.
package mips32r1_wb_pkg;

    localparam int unsigned WB_AW = 32;
    localparam int unsigned WB_DW = 32;
    localparam int unsigned WB_SW = 4;

    localparam logic [WB_DW-1:0] BUS_ERR_DATA_DEF = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        MST_I = 1'b0,
        MST_D = 1'b1
    } wb_mst_e;

    // Round-robin pick from IDLE: on a tie the master that did not
    // own the bus last time wins.
    function automatic arb_state_e arb_pick(
        input logic    i_req,
        input logic    d_req,
        input wb_mst_e last
    );
        if (i_req && (!d_req || last == MST_D)) begin
            return ST_GNT_I;
        end
        if (d_req) begin
            return ST_GNT_D;
        end
        return ST_IDLE;
    endfunction

endpackage

// File: rtl/mips32r1_wb_if.sv
// Wishbone classic bus bundle.
// master: drives adr/wdat/we/sel/stb/cyc; slave: drives rdat/ack.
// ro_slave: slave view of a read-only master (no wdat/we).
interface mips32r1_wb_if;
    import mips32r1_wb_pkg::*;

    logic [WB_AW-1:0] adr;
    logic [WB_DW-1:0] wdat;
    logic [WB_DW-1:0] rdat;
    logic             we;
    logic [WB_SW-1:0] sel;
    logic             stb;
    logic             cyc;
    logic             ack;

    modport master (
        output adr, wdat, we, sel, stb, cyc,
        input  rdat, ack
    );

    modport slave (
        input  adr, wdat, we, sel, stb, cyc,
        output rdat, ack
    );

    modport ro_slave (
        input  adr, sel, stb, cyc,
        output rdat, ack
    );

endinterface

// File: rtl/mips32r1_wb_watchdog.sv
// Bus watchdog: counts strobe cycles without ack and flags a timeout.
// Ports: clk_i/rst_i, clr_i (arbiter idle), stb_i (unforced strobe), ack_i, timeout_o.
module mips32r1_wb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic stb_i,
    input  logic ack_i,
    output logic timeout_o
);

    localparam int unsigned RAW_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CW =
        (RAW_W < 8) ? 8 : ((RAW_W > 32) ? 32 : RAW_W);
    localparam bit EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The counter restarts after a forced completion so a master that
    // keeps strobing gets a full fresh window.
    always_comb begin
        timeout_o = 1'b0;
        cnt_d     = '0;
        if (EN && !clr_i && stb_i && !ack_i) begin
            if (cnt_q == LAST) begin
                timeout_o = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mips32r1_wb_arbiter.sv
// 2-master/1-slave Wishbone classic round-robin arbiter with watchdog.
// Ports: wb_clk_i, wb_rst_i, iwbm (instr, read-only), dwbm (data),
//        wbm (shared bus master), bus_err_o pulse, err_adr_o last timeout address.
module mips32r1_wb_arbiter
    import mips32r1_wb_pkg::*;
#(
    parameter int unsigned      TIMEOUT_CYCLES = 255,
    parameter logic [WB_DW-1:0] BUS_ERR_DATA   = BUS_ERR_DATA_DEF
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    mips32r1_wb_if.ro_slave          iwbm,
    mips32r1_wb_if.slave             dwbm,
    mips32r1_wb_if.master            wbm,
    output logic                     bus_err_o,
    output logic [WB_AW-1:0]         err_adr_o
);

    arb_state_e       state_q;
    arb_state_e       state_d;
    wb_mst_e          last_q;
    wb_mst_e          last_d;
    logic [WB_AW-1:0] err_adr_q;
    logic [WB_AW-1:0] err_adr_d;

    logic             own_i;
    logic             own_d;
    logic [WB_AW-1:0] m_adr;
    logic [WB_DW-1:0] m_wdat;
    logic             m_we;
    logic [WB_SW-1:0] m_sel;
    logic             m_stb;
    logic             m_cyc;
    logic             timeout;
    logic             fin;
    logic [WB_DW-1:0] rdat;

    assign own_i = (state_q == ST_GNT_I);
    assign own_d = (state_q == ST_GNT_D);

    mips32r1_wb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk_i    (wb_clk_i),
        .rst_i    (wb_rst_i),
        .clr_i    (state_q == ST_IDLE),
        .stb_i    (m_stb),
        .ack_i    (wbm.ack),
        .timeout_o(timeout)
    );

    // Owner mux; IDLE presents an all-zero bus.
    always_comb begin
        m_adr  = '0;
        m_wdat = '0;
        m_we   = 1'b0;
        m_sel  = '0;
        m_stb  = 1'b0;
        m_cyc  = 1'b0;
        unique case (1'b1)
            own_i: begin
                m_adr = iwbm.adr;
                m_sel = iwbm.sel;
                m_stb = iwbm.stb;
                m_cyc = iwbm.cyc;
            end
            own_d: begin
                m_adr  = dwbm.adr;
                m_wdat = dwbm.wdat;
                m_we   = dwbm.we;
                m_sel  = dwbm.sel;
                m_stb  = dwbm.stb;
                m_cyc  = dwbm.cyc;
            end
            default: ;
        endcase
    end

    // A timeout kills the slave cycle and completes the master locally;
    // the watchdog never fires in a cycle that carries a real ack.
    assign wbm.adr  = m_adr;
    assign wbm.wdat = m_wdat;
    assign wbm.we   = m_we;
    assign wbm.sel  = m_sel;
    assign wbm.stb  = m_stb & ~timeout;
    assign wbm.cyc  = m_cyc & ~timeout;

    assign fin  = m_stb & (wbm.ack | timeout);
    assign rdat = timeout ? BUS_ERR_DATA : wbm.rdat;

    assign iwbm.ack  = own_i & fin;
    assign iwbm.rdat = own_i ? rdat : '0;
    assign dwbm.ack  = own_d & fin;
    assign dwbm.rdat = own_d ? rdat : '0;

    assign bus_err_o = timeout;
    assign err_adr_o = err_adr_q;

    // Ownership always returns to IDLE for one cycle before changing.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        err_adr_d = timeout ? m_adr : err_adr_q;
        unique case (state_q)
            ST_IDLE: begin
                state_d = arb_pick(iwbm.cyc, dwbm.cyc, last_q);
                if (state_d == ST_GNT_I) begin
                    last_d = MST_I;
                end else if (state_d == ST_GNT_D) begin
                    last_d = MST_D;
                end
            end
            ST_GNT_I: begin
                if (!iwbm.cyc) begin
                    state_d = ST_IDLE;
                end
            end
            ST_GNT_D: begin
                if (!dwbm.cyc) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_IDLE;
            last_q    <= MST_D;
            err_adr_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            err_adr_q <= err_adr_d;
        end
    end

endmodule

// File: tb/tb_mips32r1_wb_arbiter.sv
// Scoreboard bench for mips32r1_wb_arbiter.
// Expected acks are queued by stimulus and checked by a monitor.
module tb_mips32r1_wb_arbiter;
    import mips32r1_wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bus_err;
    logic [31:0] err_adr;

    always #5 clk = ~clk;

    mips32r1_wb_if iwb ();
    mips32r1_wb_if dwb ();
    mips32r1_wb_if sbus ();

    mips32r1_wb_arbiter #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .iwbm     (iwb),
        .dwbm     (dwb),
        .wbm      (sbus),
        .bus_err_o(bus_err),
        .err_adr_o(err_adr)
    );

    typedef struct {
        logic        is_d;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] rdat;
        logic        err;
    } exp_t;

    exp_t sbq[$];
    int   n_pass = 0;
    int   n_tot  = 0;
    int   done   = 0;
    int   w_d    = 0;
    int   slv_lat = 2;
    int   slv_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] slv_data(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic void push_e(input logic is_d, input logic [31:0] a,
                                   input logic we, input logic [31:0] wd,
                                   input logic [3:0] sel,
                                   input logic [31:0] rd, input logic err);
        exp_t e;
        e.is_d = is_d;
        e.adr  = a;
        e.we   = we;
        e.wdat = wd;
        e.sel  = sel;
        e.rdat = rd;
        e.err  = err;
        sbq.push_back(e);
    endfunction

    // Slave: acks in cycle slv_lat-1 of a strobe; slv_lat==0 never acks.
    initial begin
        sbus.ack  = 1'b0;
        sbus.rdat = '0;
        forever begin
            @(posedge clk);
            #1;
            if (sbus.ack) begin
                sbus.ack = 1'b0;
                slv_cnt  = 0;
            end else if (slv_lat != 0 && slv_cnt == slv_lat - 1) begin
                sbus.ack  = 1'b1;
                sbus.rdat = slv_data(sbus.adr);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!sbus.stb) begin
                slv_cnt = 0;
            end else if (!sbus.ack) begin
                slv_cnt++;
            end
        end
    end

    // Monitor: every master ack consumes one scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (iwb.ack || dwb.ack) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_ack", {30'b0, iwb.ack, dwb.ack}, 32'h0);
                end else begin
                    e = sbq.pop_front();
                    chk("one_ack", 32'(iwb.ack & dwb.ack), 32'h0);
                    chk("ack_owner", 32'(dwb.ack), 32'(e.is_d));
                    chk("rdat", e.is_d ? dwb.rdat : iwb.rdat, e.rdat);
                    chk("bus_err", 32'(bus_err), 32'(e.err));
                    chk("wbm_adr", sbus.adr, e.adr);
                    chk("wbm_we", 32'(sbus.we), 32'(e.we));
                    chk("wbm_dat", sbus.wdat, e.wdat);
                    chk("wbm_sel", 32'(sbus.sel), 32'(e.sel));
                end
            end
        end
    end

    task automatic i_read(input logic [31:0] a);
        int w;
        iwb.adr = a;
        iwb.sel = 4'hF;
        iwb.cyc = 1'b1;
        iwb.stb = 1'b1;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!iwb.ack && w < 200);
        chk("i_ack_seen", 32'(iwb.ack), 32'h1);
        @(posedge clk);
        #1;
        iwb.cyc = 1'b0;
        iwb.stb = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic d_acc(input logic [31:0] a, input logic we,
                         input logic [31:0] wd, input logic [3:0] sel,
                         output int w);
        dwb.adr  = a;
        dwb.we   = we;
        dwb.wdat = wd;
        dwb.sel  = sel;
        dwb.cyc  = 1'b1;
        dwb.stb  = 1'b1;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!dwb.ack && w < 200);
        chk("d_ack_seen", 32'(dwb.ack), 32'h1);
        @(posedge clk);
        #1;
        dwb.cyc = 1'b0;
        dwb.stb = 1'b0;
        dwb.we  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int n);
        int c;
        c = 0;
        while (done < n && c < 500) begin
            @(negedge clk);
            c++;
        end
        chk("tasks_done", 32'(done), 32'(n));
    endtask

    initial begin
        iwb.adr = '0; iwb.sel = '0; iwb.cyc = 1'b0; iwb.stb = 1'b0;
        iwb.wdat = '0; iwb.we = 1'b0;
        dwb.adr = '0; dwb.sel = '0; dwb.cyc = 1'b0; dwb.stb = 1'b0;
        dwb.wdat = '0; dwb.we = 1'b0;
        rst = 1'b1;
        slv_lat = 2;

        // Reset with both requesting, then alternating grants.
        push_e(1'b0, 32'h0000_1000, 1'b0, 32'h0, 4'hF,
               32'h1000_EFFF, 1'b0);
        push_e(1'b1, 32'h0000_2000, 1'b0, 32'h0, 4'hF,
               32'h2000_DFFF, 1'b0);
        push_e(1'b0, 32'h0000_1004, 1'b0, 32'h0, 4'hF,
               32'h1004_EFFB, 1'b0);
        push_e(1'b1, 32'h0000_2004, 1'b0, 32'h0, 4'hF,
               32'h2004_DFFB, 1'b0);
        fork
            begin
                i_read(32'h0000_1000);
                i_read(32'h0000_1004);
                done++;
            end
            begin
                d_acc(32'h0000_2000, 1'b0, 32'h0, 4'hF, w_d);
                d_acc(32'h0000_2004, 1'b0, 32'h0, 4'hF, w_d);
                done++;
            end
        join_none

        repeat (3) @(negedge clk);
        chk("rst_cyc", 32'(sbus.cyc), 32'h0);
        chk("rst_stb", 32'(sbus.stb), 32'h0);
        chk("rst_adr", sbus.adr, 32'h0);
        chk("rst_iack", 32'(iwb.ack), 32'h0);
        chk("rst_dack", 32'(dwb.ack), 32'h0);
        chk("rst_err", 32'(bus_err), 32'h0);
        chk("rst_err_adr", err_adr, 32'h0);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("grant1_cyc", 32'(sbus.cyc), 32'h1);
        chk("grant1_adr", sbus.adr, 32'h0000_1000);
        wait_done(2);

        // D write stalls behind an I read.
        done = 0;
        slv_lat = 4;
        push_e(1'b0, 32'h0000_1008, 1'b0, 32'h0, 4'hF,
               32'h1008_EFF7, 1'b0);
        push_e(1'b1, 32'h0000_0100, 1'b1, 32'h1234_5678, 4'b0011,
               32'h0100_FEFF, 1'b0);
        fork
            begin
                i_read(32'h0000_1008);
                done++;
            end
            begin
                @(posedge clk);
                #1;
                d_acc(32'h0000_0100, 1'b1, 32'h1234_5678, 4'b0011, w_d);
                done++;
            end
        join_none
        wait_done(2);

        // Hung slave: watchdog completes on the 8th strobe cycle.
        slv_lat = 0;
        push_e(1'b1, 32'h0000_0200, 1'b0, 32'h0, 4'hF,
               32'hDEAD_BEEF, 1'b1);
        @(posedge clk);
        #1;
        d_acc(32'h0000_0200, 1'b0, 32'h0, 4'hF, w_d);
        chk("to_latency", 32'(w_d), 32'd9);
        @(negedge clk);
        chk("to_err_adr", err_adr, 32'h0000_0200);
        chk("to_pulse_end", 32'(bus_err), 32'h0);

        // Ack on the exact timeout cycle wins.
        slv_lat = 8;
        push_e(1'b1, 32'h0000_0300, 1'b0, 32'h0, 4'hF,
               32'h0300_FCFF, 1'b0);
        @(posedge clk);
        #1;
        d_acc(32'h0000_0300, 1'b0, 32'h0, 4'hF, w_d);
        chk("late_ack_lat", 32'(w_d), 32'd9);
        @(negedge clk);
        chk("late_err_adr", err_adr, 32'h0000_0200);

        // Async reset in the middle of a D cycle.
        slv_lat = 0;
        @(posedge clk);
        #1;
        dwb.adr = 32'h0000_0400;
        dwb.sel = 4'hF;
        dwb.cyc = 1'b1;
        dwb.stb = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_cyc", 32'(sbus.cyc), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("async_cyc", 32'(sbus.cyc), 32'h0);
        chk("async_stb", 32'(sbus.stb), 32'h0);
        iwb.adr = 32'h0000_0500;
        iwb.sel = 4'hF;
        iwb.cyc = 1'b1;
        iwb.stb = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_cyc", 32'(sbus.cyc), 32'h1);
        chk("post_rst_adr", sbus.adr, 32'h0000_0500);
        iwb.cyc = 1'b0;
        iwb.stb = 1'b0;
        dwb.cyc = 1'b0;
        dwb.stb = 1'b0;
        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sbq.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
